param_data_memory: RTL

- Parametrised successor to the single-port 8-bit data memory used by the microprocessor datapath.
- Storage width and depth are parameters, and the memory is served over a request/response handshake with a registered read.
- Power-on and reset initialisation runs as a sequenced fill, one entry per cycle, instead of an all-entry parallel reset.
- Out-of-range addresses are flagged, and software can request a re-initialisation at run time.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/param_data_memory_if.sv | 26 ++
 rtl/dm_init_sequencer.sv | 61 ++++++
 rtl/param_data_memory.sv | 92 +++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the parametrised data memory: the sequencer state,
// the init fill pattern and the parameter legality check.
package dm_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } dm_state_e;

  localparam int DM_MAX_W = 64;

  // Entries below the split hold their own index; entries from the split upward
  // count down from zero in two's complement.
  function automatic logic [DM_MAX_W-1:0] init_value(input int unsigned index,
                                                     input int unsigned split);
    if (index < split) return DM_MAX_W'(index);
    return DM_MAX_W'(0) - DM_MAX_W'(index - split);
  endfunction

  function automatic bit params_ok(input int data_w, input int addr_w,
                                   input int depth, input int init_split);
    return (data_w >= 1) && (data_w <= DM_MAX_W) &&
           (addr_w >= 1) && (addr_w < 31) &&
           (depth >= 1) && (longint'(depth) <= (longint'(1) << addr_w)) &&
           (init_split >= 0) && (init_split <= depth);
  endfunction

endpackage

// File: rtl/param_data_memory_if.sv
// Request/response bus of the data memory, plus the init control and status pair.
interface param_data_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              init_start;
  logic              init_busy;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output init_start, req_valid, req_write, req_addr, req_wdata,
    input  init_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  init_start, req_valid, req_write, req_addr, req_wdata,
    output init_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_init_sequencer.sv
// Owns the INIT/READY state and the fill counter; drives one fill write per INIT cycle.
module dm_init_sequencer
  import dm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 32,
  parameter int INIT_SPLIT = 16,
  parameter int IDX_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_init_start,
  output logic              o_fill_we,
  output logic [IDX_W-1:0]  o_fill_addr,
  output logic [DATA_W-1:0] o_fill_data,
  output logic              o_init_busy,
  output logic              o_ready
);

  dm_state_e        r_state;
  dm_state_e        w_state_next;
  logic [IDX_W-1:0] r_init_cnt;
  logic [IDX_W-1:0] w_init_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    case (r_state)
      INIT: begin
        if (r_init_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_next    = READY;
          w_init_cnt_next = '0;
        end else begin
          w_init_cnt_next = r_init_cnt + 1'b1;
        end
      end
      READY: begin
        if (i_init_start) w_state_next = INIT;
      end
      default: w_state_next = INIT;
    endcase
  end

  // Status outputs decode the state flop directly, so they are glitch-free registers.
  assign o_fill_we   = (r_state == INIT);
  assign o_fill_addr = r_init_cnt;
  assign o_fill_data = DATA_W'(init_value(32'(r_init_cnt), INIT_SPLIT));
  assign o_init_busy = (r_state == INIT);
  assign o_ready     = (r_state == READY);

endmodule

// File: rtl/param_data_memory.sv
// Parametrised single-port data memory with a registered request/response port,
// a sequenced init fill and out-of-range address flagging.
module param_data_memory
  import dm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 32,
  parameter int INIT_SPLIT = 16
) (
  input logic               clk,
  input logic               reset,
  param_data_memory_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (!params_ok(DATA_W, ADDR_W, DEPTH, INIT_SPLIT)) begin : g_param_check
      $error("param_data_memory: illegal DATA_W/ADDR_W/DEPTH/INIT_SPLIT combination");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_fill_we;
  logic [IDX_W-1:0]  w_fill_addr;
  logic [DATA_W-1:0] w_fill_data;
  logic              w_busy;
  logic              w_ready;
  logic              w_accept;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  dm_init_sequencer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_SPLIT(INIT_SPLIT),
    .IDX_W     (IDX_W)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .i_init_start(bus.init_start),
    .o_fill_we   (w_fill_we),
    .o_fill_addr (w_fill_addr),
    .o_fill_data (w_fill_data),
    .o_init_busy (w_busy),
    .o_ready     (w_ready)
  );

  // Compare one bit wider than the address so DEPTH == 2**ADDR_W cannot overflow.
  assign w_in_range = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_idx      = bus.req_addr[IDX_W-1:0];
  assign w_accept   = bus.req_valid && w_ready && !reset;

  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_mem[w_fill_addr] <= w_fill_data;
    end else if (w_accept && bus.req_write && w_in_range) begin
      r_mem[w_idx] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        if (!w_in_range) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b1;
        end else begin
          r_rsp_rdata <= bus.req_write ? bus.req_wdata : r_mem[w_idx];
          r_rsp_err   <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.init_busy = w_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
